// File: rtl/arp_query_arbiter.sv
// Shares the single ARP cache query port among N_PORTS requesters.
// Grants are round-robin, with one query outstanding at a time. Each response
// goes back to the requester that issued the query. A response timeout turns a
// hung lookup into an error response. Late cache responses for queries that
// timed out are counted as stale and are discarded when they arrive.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid_i/req_ready_i/o   per-port query handshake; req_ip_i holds 32 bits per port
//   resp_valid_o/resp_ready_i   per-port response handshake; resp_error_o/resp_mac_o are shared
//   cache_req_*                 query issued to the cache (registered, held until accepted)
//   cache_resp_*                response from the cache (cache miss reported as an error)
//   busy_o                      high outside IDLE
//   timeout_pulse_o             one-cycle strobe when a lookup times out
module arp_query_arbiter #(
  parameter int N_PORTS        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_PORTS-1:0]   req_valid_i,
  output logic [N_PORTS-1:0]   req_ready_o,
  input  logic [N_PORTS*32-1:0] req_ip_i,
  output logic [N_PORTS-1:0]   resp_valid_o,
  input  logic [N_PORTS-1:0]   resp_ready_i,
  output logic                 resp_error_o,
  output logic [47:0]          resp_mac_o,
  output logic                 cache_req_valid_o,
  input  logic                 cache_req_ready_i,
  output logic [31:0]          cache_req_ip_o,
  input  logic                 cache_resp_valid_i,
  output logic                 cache_resp_ready_o,
  input  logic                 cache_resp_error_i,
  input  logic [47:0]          cache_resp_mac_i,
  output logic                 busy_o,
  output logic                 timeout_pulse_o
);

  localparam int PW     = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] TMO_VAL   = CW'(TIMEOUT_CYCLES);
  localparam logic [PW-1:0] LAST_INIT = PW'(N_PORTS - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_DELIVER = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] last_grant_q, last_grant_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [31:0]   ip_q, ip_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    stale_q, stale_d;
  logic          err_q, err_d;
  logic [47:0]   mac_q, mac_d;
  logic          creq_vld_q, creq_vld_d;

  logic          grant_vld;
  logic [PW-1:0] grant_idx;
  logic [PW-1:0] cand;
  logic [31:0]   grant_ip;
  logic          cache_req_hs;
  logic          cresp_hs;
  logic          resp_use;
  logic          stale_drop;
  logic          tmo_hit;
  logic [CW-1:0] cnt_inc;

  // Round-robin search: first requester at or after last_grant+1, wrapping.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 1; i <= N_PORTS; i++) begin
      cand = PW'((int'(last_grant_q) + i) % N_PORTS);
      if (!grant_vld && req_valid_i[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    grant_ip = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (grant_idx == PW'(k)) grant_ip = req_ip_i[k*32 +: 32];
    end
  end

  // req_ready is combinational from req_valid. Gating it with rst_n keeps a
  // requester from seeing a handshake while the state registers are held in reset.
  always_comb begin
    req_ready_o = '0;
    if (rst_n && state_q == S_IDLE && grant_vld) req_ready_o[grant_idx] = 1'b1;
  end

  always_comb begin
    resp_valid_o = '0;
    if (state_q == S_DELIVER) resp_valid_o[owner_q] = 1'b1;
  end

  assign cache_req_valid_o  = creq_vld_q;
  assign cache_req_ip_o     = ip_q;
  assign cache_resp_ready_o = (state_q != S_DELIVER);
  assign resp_error_o       = err_q;
  assign resp_mac_o         = mac_q;
  assign busy_o             = (state_q != S_IDLE);

  assign cache_req_hs = creq_vld_q && cache_req_ready_i;
  assign cresp_hs     = cache_resp_valid_i && cache_resp_ready_o;
  assign cnt_inc      = cnt_q + CW'(1);
  // While stale_q is nonzero, any accepted response belongs to an abandoned query.
  assign stale_drop   = cresp_hs && (stale_q != 4'd0);
  assign resp_use     = cresp_hs && (stale_q == 4'd0) && (state_q == S_WAIT);
  // A usable response in the same cycle as the timeout takes priority over it.
  assign tmo_hit      = TMO_EN && (state_q == S_WAIT) && (cnt_inc == TMO_VAL) && !resp_use;
  assign timeout_pulse_o = tmo_hit;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    ip_d         = ip_q;
    cnt_d        = cnt_q;
    stale_d      = stale_q;
    err_d        = err_q;
    mac_d        = mac_q;
    creq_vld_d   = creq_vld_q;

    // When a timeout and a stale drop happen in the same cycle, the count is unchanged.
    case ({tmo_hit, stale_drop})
      2'b10:   if (stale_q != 4'hF) stale_d = stale_q + 4'd1;
      2'b01:   stale_d = stale_q - 4'd1;
      default: stale_d = stale_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          ip_d         = grant_ip;
          owner_d      = grant_idx;
          last_grant_d = grant_idx;
          creq_vld_d   = 1'b1;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cache_req_hs) begin
          creq_vld_d = 1'b0;
          cnt_d      = '0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        if (resp_use) begin
          err_d   = cache_resp_error_i;
          mac_d   = cache_resp_mac_i;
          state_d = S_DELIVER;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          mac_d   = '0;
          state_d = S_DELIVER;
        end
      end
      S_DELIVER: begin
        if (resp_ready_i[owner_q]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= LAST_INIT;
      owner_q      <= '0;
      ip_q         <= '0;
      cnt_q        <= '0;
      stale_q      <= '0;
      err_q        <= 1'b0;
      mac_q        <= '0;
      creq_vld_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      ip_q         <= ip_d;
      cnt_q        <= cnt_d;
      stale_q      <= stale_d;
      err_q        <= err_d;
      mac_q        <= mac_d;
      creq_vld_q   <= creq_vld_d;
    end
  end

endmodule

// File: tb/tb_arp_query_arbiter.sv
// Bench for arp_query_arbiter: a four-port requester model and a behavioral ARP
// cache with a programmable lookup delay. A scoreboard checks each delivered
// response, and directed sequences cover backpressure, timeout and reset cases.
module tb_arp_query_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid, req_ready, resp_valid, resp_ready;
  logic [127:0] req_ip;
  logic         resp_error;
  logic [47:0]  resp_mac;
  logic         cache_req_valid, cache_req_ready;
  logic [31:0]  cache_req_ip;
  logic         cache_resp_valid, cache_resp_ready, cache_resp_error;
  logic [47:0]  cache_resp_mac;
  logic         busy, timeout_pulse;

  always #5 clk = ~clk;

  arp_query_arbiter #(.N_PORTS(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_ip_i(req_ip),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_error_o(resp_error), .resp_mac_o(resp_mac),
    .cache_req_valid_o(cache_req_valid), .cache_req_ready_i(cache_req_ready),
    .cache_req_ip_o(cache_req_ip),
    .cache_resp_valid_i(cache_resp_valid), .cache_resp_ready_o(cache_resp_ready),
    .cache_resp_error_i(cache_resp_error), .cache_resp_mac_i(cache_resp_mac),
    .busy_o(busy), .timeout_pulse_o(timeout_pulse)
  );

  typedef struct { int port; logic err; logic [47:0] mac; } exp_t;
  typedef struct { logic [31:0] ip; int cnt; } cm_t;
  typedef struct { int port; logic [31:0] ip; int delay; int lat; logic err; logic [47:0] mac; } vec_t;

  int n_vec = 0, n_bad = 0;
  int cyc = 0;
  exp_t sbq[$];
  cm_t  cmq[$];
  int   grant_log[$];
  int   want[4];
  bit   hs_pending[4];
  logic [31:0] port_ip[4];
  logic [3:0]  rdy_en;
  bit   cm_req_rdy, cm_mute, cm_late_vld, cm_inject;
  logic [31:0] cm_late_ip, cur_ip;
  int   cm_delay;
  int   last_hs_cyc, first_rv_cyc, creq_hs_cyc, tmo_cnt, tmo_cyc;
  logic        last_err;
  logic [47:0] last_mac;

  // The cache reports a miss for 99.x.x.x; otherwise the MAC is 02:00:00:00:00:<last IP octet>.
  function automatic logic cm_err(input logic [31:0] ip);
    return ip[31:24] == 8'd99;
  endfunction
  function automatic logic [47:0] cm_mac(input logic [31:0] ip);
    return (ip[31:24] == 8'd99) ? 48'h0 : {40'h02_0000_0000, ip[7:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit any_want();
    return (want[0] | want[1] | want[2] | want[3]) != 0;
  endfunction

  // Drive phase, 1 time unit after the rising edge.
  task automatic adv();
    cm_t h;
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 4; k++) begin
      if (hs_pending[k]) begin want[k]--; hs_pending[k] = 1'b0; end
      req_valid[k] = want[k] > 0;
      req_ip[k*32 +: 32] = port_ip[k];
    end
    resp_ready      = rdy_en;
    cache_req_ready = cm_req_rdy;
    if (cmq.size() > 0 && cmq[0].cnt == 0) begin
      cache_resp_valid = 1'b1;
      cache_resp_error = cm_err(cmq[0].ip);
      cache_resp_mac   = cm_mac(cmq[0].ip);
    end else begin
      cache_resp_valid = 1'b0;
      cache_resp_error = 1'b0;
      cache_resp_mac   = '0;
      if (cmq.size() > 0) begin h = cmq[0]; h.cnt--; cmq[0] = h; end
    end
  endtask

  // Sample phase, on the falling edge.
  task automatic mon();
    exp_t e;
    cm_t  c;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      if (req_valid[k] && req_ready[k]) begin
        grant_log.push_back(k);
        hs_pending[k] = 1'b1;
        last_hs_cyc   = cyc;
        first_rv_cyc  = -1;
        cur_ip        = port_ip[k];
        e.port = k;
        if (cm_mute) begin e.err = 1'b1; e.mac = '0; end
        else begin e.err = cm_err(port_ip[k]); e.mac = cm_mac(port_ip[k]); end
        sbq.push_back(e);
      end
    end
    if (cache_req_valid && cache_req_ready) begin
      chk("cache_req_ip", cache_req_ip, cur_ip);
      creq_hs_cyc = cyc;
      if (cm_inject && cm_late_vld) begin
        c.ip = cm_late_ip; c.cnt = 0; cmq.push_front(c);
        cm_late_vld = 1'b0; cm_inject = 1'b0;
      end
      if (cm_mute) begin
        cm_late_vld = 1'b1; cm_late_ip = cache_req_ip; cm_mute = 1'b0;
      end else begin
        c.ip = cache_req_ip; c.cnt = cm_delay; cmq.push_back(c);
      end
    end
    if (cache_resp_valid && cache_resp_ready && cmq.size() > 0) cmq.delete(0);
    if (timeout_pulse) begin tmo_cnt++; tmo_cyc = cyc; end
    if (resp_valid != 4'b0 && first_rv_cyc < 0) first_rv_cyc = cyc;
    if ((resp_valid & resp_ready) != 4'b0) begin
      if (sbq.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL resp_unexpected: got resp_valid=%b want none", resp_valid);
      end else begin
        e = sbq.pop_front();
        chk("resp_port", 64'(resp_valid), 64'(1) << e.port);
        chk("resp_error", 64'(resp_error), 64'(e.err));
        chk("resp_mac", resp_mac, e.mac);
        last_err = resp_error;
        last_mac = resp_mac;
      end
    end
  endtask

  task automatic tick();
    adv();
    mon();
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    do begin tick(); n++; end
    while ((busy || sbq.size() != 0 || any_want()) && n < budget);
    chk({name, "_done"}, 64'(busy || sbq.size() != 0 || any_want()), 64'(0));
  endtask

  vec_t vecs[5];
  int   rr_exp[8];
  int   rr2_exp[3];

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, t0;
    vecs[0] = '{2, 32'h0A000005, 1, 4, 1'b0, 48'h02_00_00_00_00_05};
    vecs[1] = '{0, 32'hC0A80101, 0, 3, 1'b0, 48'h02_00_00_00_00_01};
    vecs[2] = '{1, 32'h0A0000FE, 4, 7, 1'b0, 48'h02_00_00_00_00_FE};
    vecs[3] = '{0, 32'h0A000010, 5, 8, 1'b0, 48'h02_00_00_00_00_10};
    vecs[4] = '{3, 32'h63000007, 2, 5, 1'b1, 48'h0};
    rr_exp  = '{0, 1, 2, 3, 0, 1, 2, 3};
    rr2_exp = '{1, 3, 1};

    rst_n = 1'b0;
    req_valid = '0; req_ip = '0; resp_ready = '0;
    cache_req_ready = 1'b0; cache_resp_valid = 1'b0; cache_resp_error = 1'b0; cache_resp_mac = '0;
    for (int k = 0; k < 4; k++) begin want[k] = 0; hs_pending[k] = 1'b0; port_ip[k] = 32'h0A000000 + k; end
    rdy_en = 4'hF; cm_req_rdy = 1'b1; cm_mute = 1'b0; cm_late_vld = 1'b0; cm_inject = 1'b0;
    cm_delay = 1; tmo_cnt = 0; tmo_cyc = 0; first_rv_cyc = -1; last_hs_cyc = 0; creq_hs_cyc = 0;
    cur_ip = '0; cm_late_ip = '0; last_err = 1'b0; last_mac = '0;

    // Values held while reset is asserted.
    #12;
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_cache_req_valid", 64'(cache_req_valid), 64'(0));
    chk("rst_cache_req_ip", 64'(cache_req_ip), 64'(0));
    chk("rst_cache_resp_ready", 64'(cache_resp_ready), 64'(1));
    chk("rst_timeout_pulse", 64'(timeout_pulse), 64'(0));
    chk("rst_resp_mac", resp_mac, 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven single queries: one requester, checking latency and returned values.
    foreach (vecs[i]) begin
      port_ip[vecs[i].port] = vecs[i].ip;
      cm_delay = vecs[i].delay;
      want[vecs[i].port] = 1;
      wait_done($sformatf("vec%0d", i), 60);
      chk($sformatf("vec%0d_latency", i), 64'(first_rv_cyc - last_hs_cyc), 64'(vecs[i].lat));
      chk($sformatf("vec%0d_err", i), 64'(last_err), 64'(vecs[i].err));
      chk($sformatf("vec%0d_mac", i), last_mac, vecs[i].mac);
    end

    // Round-robin: all ports request continuously, eight grants.
    cm_delay = 0;
    for (int k = 0; k < 4; k++) begin port_ip[k] = 32'h0A000020 + k; want[k] = 2; end
    grant_log.delete();
    wait_done("rr_all", 200);
    chk("rr_all_count", 64'(grant_log.size()), 64'(8));
    for (int i = 0; i < 8 && i < grant_log.size(); i++)
      chk($sformatf("rr_all_grant%0d", i), 64'(grant_log[i]), 64'(rr_exp[i]));

    // Only ports 1 and 3 active after port 3 was the last grant.
    want[1] = 2; want[3] = 1;
    grant_log.delete();
    wait_done("rr_sparse", 100);
    chk("rr_sparse_count", 64'(grant_log.size()), 64'(3));
    for (int i = 0; i < 3 && i < grant_log.size(); i++)
      chk($sformatf("rr_sparse_grant%0d", i), 64'(grant_log[i]), 64'(rr2_exp[i]));

    // Cache request backpressure: the IP stays stable and no other requester is granted.
    cm_req_rdy = 1'b0; cm_delay = 1;
    port_ip[0] = 32'h0A000030; port_ip[1] = 32'h0A000031;
    want[0] = 1; want[1] = 1;
    n = 0;
    do begin tick(); n++; end while (!cache_req_valid && n < 20);
    chk("creq_bp_issue", 64'(cache_req_valid), 64'(1));
    for (int i = 0; i < 5; i++) begin
      chk("creq_bp_valid", 64'(cache_req_valid), 64'(1));
      chk("creq_bp_ip", 64'(cache_req_ip), 64'(32'h0A000030));
      chk("creq_bp_req_ready", 64'(req_ready), 64'(0));
      tick();
    end
    cm_req_rdy = 1'b1;
    wait_done("creq_bp", 60);

    // Response backpressure on port 0.
    rdy_en = 4'b1110;
    port_ip[0] = 32'h0A000040;
    want[0] = 1;
    n = 0;
    do begin tick(); n++; end while (!resp_valid[0] && n < 30);
    for (int i = 0; i < 10; i++) begin
      chk("resp_bp_valid", 64'(resp_valid), 64'(4'b0001));
      chk("resp_bp_mac", resp_mac, 48'h02_00_00_00_00_40);
      chk("resp_bp_cache_resp_ready", 64'(cache_resp_ready), 64'(0));
      tick();
    end
    rdy_en = 4'hF;
    wait_done("resp_bp", 20);

    // Timeout on query A; its late response lands during B's WAIT and must be dropped.
    t0 = tmo_cnt;
    port_ip[0] = 32'h0A0000A1; cm_mute = 1'b1; want[0] = 1;
    wait_done("tmo_a", 60);
    chk("tmo_a_pulses", 64'(tmo_cnt - t0), 64'(1));
    chk("tmo_a_cycle", 64'(tmo_cyc - creq_hs_cyc), 64'(8));
    chk("tmo_a_err", 64'(last_err), 64'(1));
    chk("tmo_a_mac", last_mac, 64'(0));
    port_ip[1] = 32'h0A0000B2; cm_delay = 3; cm_inject = 1'b1; want[1] = 1;
    wait_done("stale_b", 60);
    chk("stale_b_late_sent", 64'(cm_late_vld), 64'(0));
    chk("stale_b_late_taken", 64'(cmq.size()), 64'(0));
    chk("stale_b_mac", last_mac, 48'h02_00_00_00_00_B2);
    chk("stale_b_err", 64'(last_err), 64'(0));
    port_ip[2] = 32'h0A0000C3; cm_delay = 1; want[2] = 1;
    wait_done("stale_c", 60);
    chk("stale_c_mac", last_mac, 48'h02_00_00_00_00_C3);
    chk("stale_c_latency", 64'(first_rv_cyc - last_hs_cyc), 64'(4));
    chk("stale_no_extra_tmo", 64'(tmo_cnt - t0), 64'(1));

    // A response in WAIT cycle 8 (the timeout cycle) is delivered and no timeout fires.
    t0 = tmo_cnt;
    port_ip[3] = 32'h0A0000D4; cm_delay = 7; want[3] = 1;
    wait_done("boundary", 60);
    chk("boundary_mac", last_mac, 48'h02_00_00_00_00_D4);
    chk("boundary_err", 64'(last_err), 64'(0));
    chk("boundary_no_tmo", 64'(tmo_cnt - t0), 64'(0));
    port_ip[0] = 32'h0A0000E5; cm_delay = 1; want[0] = 1;
    wait_done("boundary_after", 60);
    chk("boundary_after_mac", last_mac, 48'h02_00_00_00_00_E5);
    chk("boundary_after_latency", 64'(first_rv_cyc - last_hs_cyc), 64'(4));

    // Reset asserted in WAIT while other requesters are waiting.
    port_ip[1] = 32'h0A0000F6; cm_mute = 1'b1; want[1] = 1;
    n = 0;
    do begin tick(); n++; end while (!cm_late_vld && n < 20);
    chk("rst_mid_reached_wait", 64'(cm_late_vld), 64'(1));
    port_ip[0] = 32'h0A000050; port_ip[2] = 32'h0A000052;
    want[0] = 1; want[2] = 1;
    tick();
    tick();
    chk("rst_mid_busy_before", 64'(busy), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req_ready", 64'(req_ready), 64'(0));
    chk("rst_mid_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_mid_busy", 64'(busy), 64'(0));
    chk("rst_mid_cache_req_valid", 64'(cache_req_valid), 64'(0));
    sbq.delete(); cmq.delete(); grant_log.delete();
    cm_late_vld = 1'b0; cm_mute = 1'b0; cm_delay = 1;
    adv();
    rst_n = 1'b1;
    mon();
    wait_done("rst_mid_after", 60);
    chk("rst_mid_grants", 64'(grant_log.size()), 64'(2));
    if (grant_log.size() > 0) chk("rst_mid_first_grant", 64'(grant_log[0]), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/arp_query_arbiter.md
# arp_query_arbiter

- Shares the single query port of the ARP cache among `N_PORTS` requesters: IP/ARP TX paths, management, and others.
- Arbitration is round-robin with one query outstanding at a time.
- Each cache response is routed back to the requester that issued the query.
- A response timeout converts a hung lookup into an error response, so no requester can stall forever.

## Interface

Parameters:

- `N_PORTS`, 4: number of requesters, range 2..16.
- `TIMEOUT_CYCLES`, 1024: cycles to wait for a cache response after the request handshake. 0 disables the timeout.

Ports:

- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `req_valid`, in, `N_PORTS`: per-port query valid.
- `req_ready`, out, `N_PORTS`: per-port query ready.
- `req_ip`, in, `N_PORTS*32`: per-port IP. Port k uses bits `[32k+31:32k]`.
- `resp_valid`, out, `N_PORTS`: per-port response valid.
- `resp_ready`, in, `N_PORTS`: per-port response ready.
- `resp_error`, out, 1: shared response error flag. Qualified by `resp_valid[k]`.
- `resp_mac`, out, 48: shared response MAC. Qualified by `resp_valid[k]`.
- `cache_req_valid`, out, 1: query request to the cache.
- `cache_req_ready`, in, 1: cache accepts the request.
- `cache_req_ip`, out, 32: queried IP.
- `cache_resp_valid`, in, 1: cache response valid.
- `cache_resp_ready`, out, 1: arbiter accepts the cache response.
- `cache_resp_error`, in, 1: cache miss.
- `cache_resp_mac`, in, 48: cache MAC.
- `busy`, out, 1: high in any state other than IDLE.
- `timeout_pulse`, out, 1: one-cycle strobe when a timeout fires.

## Operation

The FSM has four states: IDLE, ISSUE, WAIT, DELIVER.

**IDLE**
- Grant goes to the lowest index at or after `last_grant+1` (modulo `N_PORTS`) with `req_valid` high.
- `req_ready[grant]` is asserted combinationally in the same cycle. All other `req_ready` bits are 0, and all are 0 in every other state.
- On the handshake: latch `req_ip` into `ip_reg`, latch the grant index into `owner_reg` and `last_grant`, then go to ISSUE.

**ISSUE**
- `cache_req_valid` = 1 and `cache_req_ip` = `ip_reg`. Both are registered and held stable until `cache_req_ready`.
- On the handshake: clear the timeout counter and go to WAIT.

**WAIT**
- Timeout counter increments each cycle.
- On a `cache_resp` handshake with `stale_cnt` = 0: latch error and MAC, then go to DELIVER.
- On a `cache_resp` handshake with `stale_cnt` > 0: drop the response, decrement `stale_cnt`, stay in WAIT.
- When the counter reaches `TIMEOUT_CYCLES` (nonzero) without a usable response:
  - error = 1, MAC = 0;
  - `stale_cnt` += 1, saturating at 15;
  - `timeout_pulse` = 1;
  - go to DELIVER.

**DELIVER**
- `resp_valid[owner_reg]` = 1 with the latched `resp_error`/`resp_mac`; all other `resp_valid` bits are 0.
- Outputs are held stable until `resp_ready[owner_reg]`, then return to IDLE.

**`cache_resp_ready`**
- 1 in IDLE, ISSUE and WAIT; 0 in DELIVER.
- A cache response arriving in IDLE or ISSUE is dropped. It decrements `stale_cnt` if `stale_cnt` > 0; otherwise it is ignored.

**Reset values**
- State IDLE; `last_grant` = `N_PORTS-1`, so port 0 wins first.
- `stale_cnt`, counter, `ip_reg`, `owner_reg` = 0.
- All outputs 0, except `cache_resp_ready` = 1 after reset.

**Widths**
- Counter width is `$clog2(TIMEOUT_CYCLES+1)`, minimum 1.
- `owner_reg` and `last_grant` width is `$clog2(N_PORTS)`.

## Timing

- **Minimum request-to-response latency** (cache ready immediately, 1-cycle cache response): request handshake at cycle 0, ISSUE at cycle 1, WAIT from cycle 2, `resp_valid` the cycle after the `cache_resp` handshake. Equivalently, cache lookup time + 3 cycles.
- **Throughput**: one query per (latency + 1) cycles. The arbiter does not pipeline.
- **Simultaneous requests**: exactly one grant per IDLE visit. A port that drops `req_valid` before its grant is never granted.
- **Timeout boundary**: if a cache response and counter == `TIMEOUT_CYCLES` occur in the same cycle, the response wins. The timeout is not taken and `stale_cnt` is unchanged.
- **Reset mid-operation**: immediate return to the reset values.
  - Any in-flight cache query is forgotten. `stale_cnt` is 0, so its response, if it arrives in IDLE, is dropped.
  - If it arrives in WAIT of a new query it is accepted; the system resets the cache together with the arbiter.
- **`N_PORTS` wrap**: after granting port `N_PORTS-1`, the search starts at port 0.

## Test plan

- **Single hit**: port 2 queries 10.0.0.5; the cache answers error=0, MAC 02:00:00:00:00:05 after 1 cycle. Required: `resp_valid[2]` with that MAC exactly 4 cycles after the `req_ready[2]` handshake; no other `resp_valid` bit asserted.
- **Round-robin**: all 4 ports hold `req_valid` continuously for 8 queries. Required grant order 0,1,2,3,0,1,2,3. Then with only ports 1 and 3 active after granting 3: grant order 1,3,1.
- **Backpressure**:
  - `cache_req_ready` low for 5 cycles: required `cache_req_ip` stable and no `req_ready` asserted.
  - `resp_ready[0]` low for 10 cycles: required `resp_valid[0]`/MAC stable and `cache_resp_ready` = 0.
- **Timeout and stale drop**: `TIMEOUT_CYCLES` = 8, the cache never answers query A. Required:
  - `timeout_pulse` in cycle 8 of WAIT;
  - A's requester gets error=1, MAC=0.
  - The late response for A arrives during query B's WAIT; required: it is dropped (`stale_cnt` 1→0), and B's real response is delivered to B.
- **Boundary collision**: `cache_resp_valid` in the same cycle the counter reaches `TIMEOUT_CYCLES`. Required: the real response is delivered, no `timeout_pulse`, `stale_cnt` = 0.
- **Reset mid-WAIT**: assert `rst_n` = 0 during WAIT. Required on the asynchronous edge:
  - all `req_ready`/`resp_valid` = 0, `busy` = 0;
  - after release, the first grant goes to port 0.
